// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and counter-width helper shared by the serial adder
package serial_adder_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/full_adder_using_mux.sv
// full_adder_using_mux: 1-bit full adder built from 2:1 mux selections
module full_adder_using_mux (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  logic p;
  always_comb begin
    p     = a ? ~b : b;
    sum   = c ? ~p : p;
    carry = p ? c : a;
  end
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencing one full-adder cell LSB-first
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_w(WIDTH);
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_s_q, sh_s_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_sum, fa_carry, last;
  logic [WIDTH-1:0] s_nxt;
  full_adder_using_mux u_fa (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .c    (carry_q),
    .sum  (fa_sum),
    .carry(fa_carry)
  );
  // shift form keeps the insert-at-MSB legal when WIDTH is 1
  assign s_nxt = (sh_s_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  assign last  = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_s_d  = sh_s_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == S_IDLE && start) begin
      state_d = S_RUN;
      sh_a_d  = a;
      sh_b_d  = b;
      carry_d = cin;
      sh_s_d  = '0;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      sh_s_d  = s_nxt;
      sh_a_d  = sh_a_q >> 1;
      sh_b_d  = sh_b_q >> 1;
      carry_d = fa_carry;
      cnt_d   = cnt_q + CW'(1);
      state_d = last ? S_DONE : S_RUN;
      sum_d   = last ? s_nxt : sum_q;
      cout_d  = last ? fa_carry : cout_q;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_s_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_s_q  <= sh_s_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy = state_q == S_RUN;
  assign done = state_q == S_DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized and directed checks of serial_adder_ctrl at WIDTH 8, 1 and 4
module tb_serial_adder_ctrl;
  logic clk = 0, rst_n = 0;
  logic start8 = 0, cin8 = 0, busy8, done8, cout8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic start1 = 0, a1 = 0, b1 = 0, cin1 = 0, busy1, done1, sum1, cout1;
  logic start4 = 0, cin4 = 0, busy4, done4, cout4;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic [8:0] last8 = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
  serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c, input string nm);
    logic [8:0] exp_v;
    int n;
    exp_v = 9'(x) + 9'(y) + 9'(c);
    a8 = x; b8 = y; cin8 = c; start8 = 1;
    step();
    start8 = 0; a8 = ~x; b8 = ~y; cin8 = ~c;
    n = 0;
    while (!done8 && n < 20) begin
      checks++;
      if (busy8 !== 1'b1 || {cout8, sum8} !== last8) begin
        errors++;
        $display("FAIL %s run-phase busy=%b result=%h expected busy=1 result=%h", nm, busy8, {cout8, sum8}, last8);
      end
      step();
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL %s latency edges=%0d expected 8", nm, n);
    end
    checks++;
    if ({cout8, sum8} !== exp_v) begin
      errors++;
      $display("FAIL %s result got %h expected %h", nm, {cout8, sum8}, exp_v);
    end
    step();
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s post-done done=%b busy=%b expected 0 0", nm, done8, busy8);
    end
    last8 = exp_v;
  endtask
  task automatic test_reset();
    checks++;
    if ({busy8, done8, cout8, sum8, busy1, done1, sum1, cout1, busy4, done4, cout4, sum4} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %b expected all zero",
        {busy8, done8, cout8, sum8, busy1, done1, sum1, cout1, busy4, done4, cout4, sum4});
    end
  endtask
  task automatic test_directed();
    run8(8'h00, 8'h00, 1'b0, "t1_zero");
    run8(8'hFF, 8'h01, 1'b0, "t2_ff_01");
    run8(8'hA5, 8'h5A, 1'b1, "t2_a5_5a");
  endtask
  task automatic test_random();
    for (int i = 0; i < 20; i++) run8(8'($urandom), 8'($urandom), 1'($urandom), "random");
  endtask
  task automatic test_back_to_back();
    logic [8:0] q[$];
    logic [8:0] e;
    logic exp_done;
    start8 = 1;
    for (int k = 0; k < 40; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (k % 10 == 0) q.push_back(9'(a8) + 9'(b8) + 9'(cin8));
      step();
      exp_done = (k % 10 == 8);
      checks++;
      if (done8 !== exp_done) begin
        errors++;
        $display("FAIL held_start done at edge %0d got %b expected %b", k, done8, exp_done);
      end
      if (exp_done) begin
        e = q.pop_front();
        checks++;
        if ({cout8, sum8} !== e) begin
          errors++;
          $display("FAIL held_start result got %h expected %h", {cout8, sum8}, e);
        end
        last8 = e;
      end
    end
    start8 = 0;
    step();
  endtask
  task automatic test_reset_mid_run();
    a8 = 8'h3C; b8 = 8'h0F; cin8 = 0; start8 = 1;
    step();
    start8 = 0;
    repeat (3) step();
    rst_n = 0;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'h0) begin
      errors++;
      $display("FAIL abort outputs busy=%b done=%b cout=%b sum=%h expected all zero", busy8, done8, cout8, sum8);
    end
    step();
    rst_n = 1;
    last8 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL abort no_done done=%b busy=%b expected 0 0", done8, busy8);
      end
    end
    run8(8'h3C, 8'h0F, 1'b0, "after_abort");
  endtask
  task automatic test_width1();
    logic [1:0] e;
    for (int v = 0; v < 8; v++) begin
      a1 = v[0]; b1 = v[1]; cin1 = v[2];
      e = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
      start1 = 1;
      step();
      start1 = 0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1 run busy=%b done=%b expected 1 0", busy1, done1);
      end
      step();
      checks++;
      if (done1 !== 1'b1 || {cout1, sum1} !== e) begin
        errors++;
        $display("FAIL w1 combo %0d done=%b result=%b expected done=1 result=%b", v, done1, {cout1, sum1}, e);
      end
      step();
      checks++;
      if (done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1 pulse done=%b expected 0", done1);
      end
    end
  endtask
  task automatic test_width4();
    logic [4:0] e;
    int n;
    for (int v = 0; v < 512; v++) begin
      a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8];
      e = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
      start4 = 1;
      step();
      start4 = 0;
      n = 0;
      while (!done4 && n < 10) begin
        step();
        n++;
      end
      checks++;
      if (n != 4 || {cout4, sum4} !== e) begin
        errors++;
        $display("FAIL w4 case %0d latency=%0d result=%h expected latency=4 result=%h", v, n, {cout4, sum4}, e);
      end
      step();
    end
  endtask
  initial begin
    repeat (2) step();
    rst_n = 1;
    step();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    test_width4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
